// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if -- bundles the frame sequencer's control, preamble,
// payload and output-symbol signals.
//   master : sequencer side (drives pre_reset/pre_enable/pay_ready/sym_*/status)
//   slave  : environment side (drives start/pre_symbol/pay_*/sym_ready)
interface frame_sequencer_if;
  logic       start;
  logic       pre_reset;
  logic       pre_enable;
  logic [3:0] pre_symbol;
  logic [3:0] pay_data;
  logic       pay_valid;
  logic       pay_last;
  logic       pay_ready;
  logic [3:0] sym_out;
  logic       sym_valid;
  logic       sym_ready;
  logic       busy;
  logic       done;
  logic       abort;

  modport master (
    input  start, pre_symbol, pay_data, pay_valid, pay_last, sym_ready,
    output pre_reset, pre_enable, pay_ready, sym_out, sym_valid, busy, done, abort
  );
  modport slave (
    output start, pre_symbol, pay_data, pay_valid, pay_last, sym_ready,
    input  pre_reset, pre_enable, pay_ready, sym_out, sym_valid, busy, done, abort
  );
endinterface

// File: rtl/frame_sequencer.sv
// frame_sequencer -- emits one frame per start request: PREAMBLE_LEN symbols
// pulled from an external preamble generator, the payload stream up to and
// including pay_last, then GUARD_LEN zero symbols, all through a single
// registered output slot (sym_out/sym_valid with sym_ready backpressure).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : frame_sequencer_if.master (start, preamble generator control,
//                payload handshake, output symbol handshake, busy/done/abort)
// Optional feature: define FRAME_TIMEOUT_EN to abort a frame whose payload
// stalls for TIMEOUT_CYCLES consecutive free cycles; otherwise abort is 0.
module frame_sequencer #(
  parameter int PREAMBLE_LEN   = 64,
  parameter int GUARD_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  frame_sequencer_if.master  bus
);
  typedef enum logic [2:0] {IDLE, LOAD, PREAMBLE, PAYLOAD, GUARD} state_t;

  localparam logic [9:0] PRE_LAST   = 10'(PREAMBLE_LEN - 1);
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_LEN - 1);

  state_t     state, state_nxt;
  logic [9:0] pre_cnt;
  logic [3:0] guard_cnt;
  logic       free, accept, timeout_hit;
  logic       pre_reset, pre_enable, pay_ready, load, frame_end;
  logic [3:0] load_sym;

  // Output slot can take a new symbol when empty or being drained this cycle.
  assign free   = !bus.sym_valid || bus.sym_ready;
  assign accept = (state == PAYLOAD) && free && bus.pay_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (bus.start) state_nxt = LOAD;
      LOAD:     state_nxt = PREAMBLE;
      PREAMBLE: if (free && pre_cnt == PRE_LAST) state_nxt = PAYLOAD;
      PAYLOAD: begin
        if (timeout_hit)                state_nxt = IDLE;
        else if (accept && bus.pay_last) state_nxt = (GUARD_LEN == 0) ? IDLE : GUARD;
      end
      GUARD:    if (frame_end) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    pre_reset  = 1'b0;
    pre_enable = 1'b0;
    pay_ready  = 1'b0;
    load       = 1'b0;
    load_sym   = 4'h0;
    frame_end  = 1'b0;
    unique case (state)
      LOAD:     pre_reset = 1'b1;
      PREAMBLE: begin
        pre_enable = free;
        load       = free;
        load_sym   = bus.pre_symbol;
      end
      PAYLOAD:  begin
        pay_ready  = free;
        load       = accept;
        load_sym   = bus.pay_data;
        frame_end  = accept && bus.pay_last && (GUARD_LEN == 0);
      end
      GUARD:    begin
        load       = free;
        frame_end  = free && (guard_cnt == GUARD_LAST);
      end
      default: ;
    endcase
  end

  // Preamble and guard counters restart whenever the sequencer is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt   <= '0;
      guard_cnt <= '0;
    end else if (state == IDLE) begin
      pre_cnt   <= '0;
      guard_cnt <= '0;
    end else begin
      if (pre_enable)              pre_cnt   <= pre_cnt + 10'd1;
      if (state == GUARD && free)  guard_cnt <= guard_cnt + 4'd1;
    end
  end

  // Output slot: load when free, otherwise hold until drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sym_out   <= 4'h0;
      bus.sym_valid <= 1'b0;
    end else if (load) begin
      bus.sym_out   <= load_sym;
      bus.sym_valid <= 1'b1;
    end else if (bus.sym_ready) begin
      bus.sym_valid <= 1'b0;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            starve;

  // Only free cycles with nothing offered count as a stall; backpressured
  // cycles neither count nor clear.
  assign starve      = (state == PAYLOAD) && free && !bus.pay_valid;
  assign timeout_hit = starve && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          to_cnt <= '0;
    else if (state != PAYLOAD || accept) to_cnt <= '0;
    else if (starve)                     to_cnt <= to_cnt + 1'b1;
  end

  assign bus.abort = timeout_hit;
`else
  assign timeout_hit = 1'b0;
  assign bus.abort   = 1'b0;
`endif

  assign bus.pre_reset  = pre_reset;
  assign bus.pre_enable = pre_enable;
  assign bus.pay_ready  = pay_ready;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = frame_end;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer -- randomized bench for frame_sequencer. Expected output
// is a queue of symbols built per frame (preamble, payload, guard zeros) and
// consumed on every output handshake; frame-level counts are checked at the
// end of each frame. A second instance covers the zero-guard configuration.
module tb_frame_sequencer;
  localparam int P = 4;
  localparam int G = 2;
  localparam int T = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_sequencer_if bus ();
  frame_sequencer_if bus0 ();

  frame_sequencer #(.PREAMBLE_LEN(P), .GUARD_LEN(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  frame_sequencer #(.PREAMBLE_LEN(2), .GUARD_LEN(0), .TIMEOUT_CYCLES(T)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Preamble generator model: symbol is a fixed function of its index.
  function automatic logic [3:0] pre_sym(input int i);
    return 4'((i * 5 + 3) % 16);
  endfunction

  int pre_idx;
  always @(posedge clk or posedge reset) begin
    if (reset)               pre_idx <= 0;
    else if (bus.pre_reset)  pre_idx <= 0;
    else if (bus.pre_enable) pre_idx <= pre_idx + 1;
  end
  assign bus.pre_symbol = pre_sym(pre_idx);

  logic [3:0] sym_q[$];
  logic [4:0] pay_q[$];
  logic [3:0] last_exp;
  int  pre_pulses, pre_resets, done_cnt, abort_cnt, pay_idle, abort_at;
  bit  acc, ready_always, stall_req, noise_en, start_req;
  int  gap, stall_left;

  // Monitor: sampled at negedge, away from the active edge.
  logic [3:0] prev_sym;
  bit prev_stall, done_pend;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0; done_pend = 0; acc = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.sym_valid, 1);
        chk("hold_sym", bus.sym_out, prev_sym);
      end
      if (done_pend) begin
        chk("done_last_sym", bus.sym_out, last_exp);
        chk("done_last_vld", bus.sym_valid, 1);
        done_pend = 0;
      end
      if (bus.sym_valid && !bus.sym_ready) begin
        chk("stall_pre_en", bus.pre_enable, 0);
        chk("stall_pay_rdy", bus.pay_ready, 0);
      end
      if (!bus.busy) begin
        chk("idle_pay_rdy", bus.pay_ready, 0);
        chk("idle_pre_en", bus.pre_enable, 0);
      end
`ifndef FRAME_TIMEOUT_EN
      chk("abort_tied", bus.abort, 0);
`endif
      if (bus.sym_valid && bus.sym_ready) begin
        chk("sym_avail", sym_q.size() > 0, 1);
        if (sym_q.size() > 0) chk("sym_out", bus.sym_out, sym_q.pop_front());
      end
      if (bus.done) begin
        chk("done_pos", sym_q.size(), 1);
        done_cnt++;
        done_pend = 1;
      end
      pre_pulses += int'(bus.pre_enable);
      pre_resets += int'(bus.pre_reset);
      if (bus.busy && bus.pay_ready && !bus.pay_valid) pay_idle++;
      if (bus.abort) begin
        abort_cnt++;
        abort_at = pay_idle;
      end
      acc        = bus.pay_valid && bus.pay_ready;
      prev_stall = bus.sym_valid && !bus.sym_ready;
      prev_sym   = bus.sym_out;
    end
  end

  // Driver: updates inputs 1 time unit after each active edge.
  always @(posedge clk) begin
    #1;
    if (acc && pay_q.size() > 0) pay_q.delete(0);
    acc = 0;
    if (pay_q.size() > 0) begin
      bus.pay_valid = (gap >= 3) || ($urandom_range(0, 3) != 0);
      gap = bus.pay_valid ? 0 : gap + 1;
      {bus.pay_last, bus.pay_data} = pay_q[0];
    end else begin
      bus.pay_valid = 1'b0;
      bus.pay_last  = 1'($urandom);
      bus.pay_data  = 4'($urandom);
    end
    if (stall_req && pre_pulses >= 2) begin
      stall_left = 5;
      stall_req  = 0;
    end
    if (stall_left > 0) begin
      bus.sym_ready = 1'b0;
      stall_left--;
    end else begin
      bus.sym_ready = ready_always || ($urandom_range(0, 3) != 0);
    end
    if (start_req) begin
      bus.start = 1'b1;
      start_req = 0;
    end else begin
      bus.start = bus.busy && noise_en && ($urandom_range(0, 2) == 0);
    end
  end

  task automatic run_frame(input int n, input bit rdy, input bit stall, input bit noise);
    logic [3:0] d;
    bit fin;
    d = 4'h0;
    ready_always = rdy; stall_req = stall; noise_en = noise;
    pre_pulses = 0; pre_resets = 0; done_cnt = 0; abort_cnt = 0;
    for (int i = 0; i < P; i++) sym_q.push_back(pre_sym(i));
    for (int i = 0; i < n; i++) begin
      d = 4'($urandom);
      pay_q.push_back({i == n - 1, d});
      sym_q.push_back(d);
    end
    for (int i = 0; i < G; i++) sym_q.push_back(4'h0);
    last_exp  = (G > 0) ? 4'h0 : d;
    start_req = 1;
    fin = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #2;
      fin = (done_cnt > 0) && (sym_q.size() == 0) && !bus.busy;
      if (fin) break;
    end
    chk("frame_end", fin, 1);
    chk("pre_pulses", pre_pulses, P);
    chk("pre_reset_cnt", pre_resets, 1);
    chk("done_cnt", done_cnt, 1);
    chk("abort_cnt", abort_cnt, 0);
    chk("busy_end", bus.busy, 0);
  endtask

  initial begin
    bit hit;
    logic [3:0] d;
    bus.start = 0; bus.pay_valid = 0; bus.pay_last = 0; bus.pay_data = 0; bus.sym_ready = 1;
    bus0.start = 0; bus0.pre_symbol = 4'h5; bus0.pay_data = 4'hA; bus0.pay_last = 1;
    bus0.pay_valid = 1; bus0.sym_ready = 1;
    gap = 0; stall_left = 0; ready_always = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_sym_valid", bus.sym_valid, 0);
    chk("rst_sym_out", bus.sym_out, 0);
    chk("rst_pre_reset", bus.pre_reset, 0);
    reset = 0;
    @(posedge clk); #2;
    chk("post_rst_idle", bus.busy, 0);

    // Zero-guard instance: done on the single payload symbol, idle next cycle.
    bus0.start = 1;
    @(posedge clk); #1 bus0.start = 0;
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.done) begin
        chk("g0_done_on_pay", bus0.pay_valid && bus0.pay_ready, 1);
        @(negedge clk);
        chk("g0_busy_next", bus0.busy, 0);
        chk("g0_sym", bus0.sym_out, 4'hA);
        chk("g0_valid", bus0.sym_valid, 1);
        hit = 1;
        break;
      end
    end
    chk("g0_done_seen", hit, 1);
    bus0.pay_valid = 0;
    @(posedge clk); #1;

    // Directed: full-rate frame with three payload symbols.
    run_frame(3, 1, 0, 0);
    // Directed: five-cycle backpressure in the middle of the preamble.
    run_frame(3, 1, 1, 0);
    // Random frames with random backpressure, payload gaps and spurious starts.
    for (int f = 0; f < 8; f++) run_frame($urandom_range(1, 6), 0, 0, 1);

    // Reset in the middle of the payload.
    ready_always = 1; noise_en = 0; pre_pulses = 0; done_cnt = 0;
    for (int i = 0; i < P; i++) sym_q.push_back(pre_sym(i));
    for (int i = 0; i < 6; i++) begin
      d = 4'($urandom);
      pay_q.push_back({i == 5, d});
      sym_q.push_back(d);
    end
    start_req = 1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (pay_q.size() <= 4) break;
    end
    chk("rst_reach_payload", pay_q.size() <= 4, 1);
    #1 reset = 1;
    #1;
    chk("arst_sym_out", bus.sym_out, 0);
    chk("arst_sym_valid", bus.sym_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_abort", bus.abort, 0);
    chk("arst_pre_en", bus.pre_enable, 0);
    chk("arst_pre_rst", bus.pre_reset, 0);
    chk("arst_pay_rdy", bus.pay_ready, 0);
    @(posedge clk); #2;
    sym_q.delete(); pay_q.delete();
    chk("arst_no_done", done_cnt, 0);
    @(posedge clk); #3 reset = 0;
    #1 chk("arst_idle_after", bus.busy, 0);
    @(posedge clk); #1;
    run_frame(2, 0, 0, 0);

`ifdef FRAME_TIMEOUT_EN
    // Payload never offered: abort after T free starved cycles, no guard.
    ready_always = 1; noise_en = 0;
    pre_pulses = 0; done_cnt = 0; abort_cnt = 0; pay_idle = 0; abort_at = 0;
    for (int i = 0; i < P; i++) sym_q.push_back(pre_sym(i));
    start_req = 1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #2;
      if (abort_cnt > 0) break;
    end
    chk("to_abort_cnt", abort_cnt, 1);
    chk("to_abort_at", abort_at, T);
    chk("to_no_done", done_cnt, 0);
    chk("to_idle", bus.busy, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("to_no_guard", sym_q.size(), 0);
    chk("to_abort_once", abort_cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
